alu_control_seq: RTL and testbench

Parametrised, registered successor to the combinational ALU control decoder. It sits at the ID/EX boundary and decodes ALUOp plus funct into ALU select, shift-amount select and jr flag. It sequences multi-cycle multiply (and optionally divide) operations with a counter/FSM, raising Stall to the hazard unit until the result is ready. It also supports flush and flags illegal funct codes.

---
 rtl/alu_control_seq.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_alu_control_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// -----------------------------------------------------------------------------
// alu_control_seq
//
// Registered ALU control decoder for the ID/EX boundary. It decodes ALUOp and
// the R-type funct field into an ALU select, a shift-amount select and a jr
// flag. Multiply (and, optionally, divide) operations take several cycles. A
// small IDLE/BUSY FSM with a down-counter sequences them and raises Stall to
// the hazard unit until the result is ready.
//
// Optional feature macro: ALUCTL_DIV_EN
//   defined   : funct 011010/011011 decode to div/divu. They are multi-cycle
//               with DIV_LAT cycles.
//   undefined : those funct codes are illegal and DIV_LAT is not used.
//
// Parameters:
//   SIG_W   - ALUSignal width (>= 4)
//   MUL_LAT - accept-to-Out_Valid cycles for mult/multu (>= 1)
//   DIV_LAT - accept-to-Out_Valid cycles for div/divu (>= 1)
//   CNT_W   - latency counter width, must hold the largest latency
//
// Ports:
//   Clk         in   rising-edge clock
//   Rst_n       in   asynchronous active-low reset
//   In_Valid    in   decode inputs valid this cycle
//   Flush       in   synchronous kill of the current/incoming op
//   ALUOp       in   [2:0] main-control op class
//   IFiveToZero in   [5:0] instruction funct field
//   ALUSignal   out  [SIG_W-1:0] registered ALU select
//   SAControl   out  registered: shift uses shamt
//   ALU_C       out  registered: jr
//   HiLoWrite   out  registered: op writes HI/LO
//   Out_Valid   out  registered: op complete, outputs final
//   Stall       out  registered: block busy, upstream must hold
//   Illegal     out  registered: unrecognised funct, pulses with Out_Valid
// -----------------------------------------------------------------------------
module alu_control_seq #(
    parameter int SIG_W   = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    input  logic             Flush,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       IFiveToZero,
    output logic [SIG_W-1:0] ALUSignal,
    output logic             SAControl,
    output logic             ALU_C,
    output logic             HiLoWrite,
    output logic             Out_Valid,
    output logic             Stall,
    output logic             Illegal
);

    // ALU select codes (4-bit core; zero-extended to SIG_W)
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;
`ifdef ALUCTL_DIV_EN
    localparam logic [3:0] ALU_DIV  = 4'd12;
    localparam logic [3:0] ALU_DIVU = 4'd13;
    localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LAT);
`endif

    localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    // Elaboration-time parameter sanity checks
    generate
        if (SIG_W < 4) begin : g_chk_sig_w
            $error("alu_control_seq: SIG_W must be >= 4");
        end
        if (MUL_LAT < 1) begin : g_chk_mul_lat
            $error("alu_control_seq: MUL_LAT must be >= 1");
        end
        if (DIV_LAT < 1) begin : g_chk_div_lat
            $error("alu_control_seq: DIV_LAT must be >= 1");
        end
        if (MUL_LAT >= (2 ** CNT_W)) begin : g_chk_cnt_mul
            $error("alu_control_seq: CNT_W too small for MUL_LAT");
        end
`ifdef ALUCTL_DIV_EN
        if (DIV_LAT >= (2 ** CNT_W)) begin : g_chk_cnt_div
            $error("alu_control_seq: CNT_W too small for DIV_LAT");
        end
`endif
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;

    logic [3:0]       dec_code_s;
    logic             dec_sa_s;
    logic             dec_jr_s;
    logic             dec_hilo_s;
    logic             dec_ill_s;
    logic             dec_multi_s;
    logic [CNT_W-1:0] dec_lat_s;
    logic             go_busy_s;

    // Combinational decode of ALUOp/funct into ALU controls and op latency
    always_comb begin
        dec_code_s  = ALU_ADD;
        dec_sa_s    = 1'b0;
        dec_jr_s    = 1'b0;
        dec_hilo_s  = 1'b0;
        dec_ill_s   = 1'b0;
        dec_multi_s = 1'b0;
        dec_lat_s   = CNT_ONE;
        case (ALUOp)
            3'b000: begin
                case (IFiveToZero)
                    6'b100000, 6'b100001: dec_code_s = ALU_ADD;
                    6'b100010, 6'b100011: dec_code_s = ALU_SUB;
                    6'b100100:            dec_code_s = ALU_AND;
                    6'b100101:            dec_code_s = ALU_OR;
                    6'b100110:            dec_code_s = ALU_XOR;
                    6'b100111:            dec_code_s = ALU_NOR;
                    6'b101010:            dec_code_s = ALU_SLT;
                    6'b101011:            dec_code_s = ALU_SLTU;
                    6'b000000: begin
                        dec_code_s = ALU_SLL;
                        dec_sa_s   = 1'b1;
                    end
                    6'b000010: begin
                        dec_code_s = ALU_SRL;
                        dec_sa_s   = 1'b1;
                    end
                    6'b000011: begin
                        dec_code_s = ALU_SRA;
                        dec_sa_s   = 1'b1;
                    end
                    6'b001000: begin
                        dec_code_s = ALU_ADD;
                        dec_jr_s   = 1'b1;
                    end
                    6'b011000, 6'b011001: begin
                        dec_code_s  = ALU_MUL;
                        dec_hilo_s  = 1'b1;
                        dec_multi_s = 1'b1;
                        dec_lat_s   = MUL_LAT_C;
                    end
`ifdef ALUCTL_DIV_EN
                    6'b011010: begin
                        dec_code_s  = ALU_DIV;
                        dec_hilo_s  = 1'b1;
                        dec_multi_s = 1'b1;
                        dec_lat_s   = DIV_LAT_C;
                    end
                    6'b011011: begin
                        dec_code_s  = ALU_DIVU;
                        dec_hilo_s  = 1'b1;
                        dec_multi_s = 1'b1;
                        dec_lat_s   = DIV_LAT_C;
                    end
`endif
                    default: begin
                        dec_code_s = ALU_ADD;
                        dec_ill_s  = 1'b1;
                    end
                endcase
            end
            3'b001:  dec_code_s = ALU_OR;
            3'b010:  dec_code_s = ALU_ADD;
            3'b011:  dec_code_s = ALU_SUB;
            3'b100:  dec_code_s = ALU_AND;
            3'b101:  dec_code_s = ALU_XOR;
            3'b110:  dec_code_s = ALU_SLT;
            3'b111:  dec_code_s = ALU_SLTU;
            default: dec_code_s = ALU_ADD;
        endcase
    end

    // A multi-cycle op with latency 1 behaves exactly like a single-cycle op
    always_comb begin
        if (dec_multi_s && (dec_lat_s > CNT_ONE)) begin
            go_busy_s = 1'b1;
        end else begin
            go_busy_s = 1'b0;
        end
    end

    // Sequencer FSM: latches the decode on accept and counts multi-cycle ops down
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            ALUSignal <= '0;
            SAControl <= 1'b0;
            ALU_C     <= 1'b0;
            HiLoWrite <= 1'b0;
            Out_Valid <= 1'b0;
            Stall     <= 1'b0;
            Illegal   <= 1'b0;
        end else if (Flush) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            ALUSignal <= '0;
            SAControl <= 1'b0;
            ALU_C     <= 1'b0;
            HiLoWrite <= 1'b0;
            Out_Valid <= 1'b0;
            Stall     <= 1'b0;
            Illegal   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (In_Valid) begin
                        ALUSignal <= SIG_W'(dec_code_s);
                        SAControl <= dec_sa_s;
                        ALU_C     <= dec_jr_s;
                        HiLoWrite <= dec_hilo_s;
                        Illegal   <= dec_ill_s;
                        if (go_busy_s) begin
                            state_r   <= ST_BUSY;
                            cnt_r     <= dec_lat_s - CNT_ONE;
                            Out_Valid <= 1'b0;
                            Stall     <= 1'b1;
                        end else begin
                            state_r   <= ST_IDLE;
                            cnt_r     <= CNT_ZERO;
                            Out_Valid <= 1'b1;
                            Stall     <= 1'b0;
                        end
                    end else begin
                        state_r   <= ST_IDLE;
                        cnt_r     <= CNT_ZERO;
                        ALUSignal <= '0;
                        SAControl <= 1'b0;
                        ALU_C     <= 1'b0;
                        HiLoWrite <= 1'b0;
                        Out_Valid <= 1'b0;
                        Stall     <= 1'b0;
                        Illegal   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // Decode outputs stay held; In_Valid is ignored here
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r   <= ST_IDLE;
                        Stall     <= 1'b0;
                        Out_Valid <= 1'b1;
                    end else begin
                        state_r   <= ST_BUSY;
                        Stall     <= 1'b1;
                        Out_Valid <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= CNT_ZERO;
                    ALUSignal <= '0;
                    SAControl <= 1'b0;
                    ALU_C     <= 1'b0;
                    HiLoWrite <= 1'b0;
                    Out_Valid <= 1'b0;
                    Stall     <= 1'b0;
                    Illegal   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// -----------------------------------------------------------------------------
// Testbench for alu_control_seq (default parameters). Expected output records
// are queued when a cycle's stimulus is driven. They are popped and compared
// one time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_alu_control_seq;

    typedef struct packed {
        logic [3:0] sig;
        logic       sa;
        logic       jr;
        logic       hilo;
        logic       ov;
        logic       stall;
        logic       ill;
    } out_t;

    typedef struct {
        logic       v;
        logic [2:0] op;
        logic [5:0] fn;
        out_t       exp;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       flush;
    logic [2:0] aluop;
    logic [5:0] funct;
    logic [3:0] alu_signal;
    logic       sa_control;
    logic       alu_c;
    logic       hilo_write;
    logic       out_valid;
    logic       stall;
    logic       illegal;

    int n_checks = 0;
    int n_fail   = 0;

    out_t  exp_q[$];
    string name_q[$];
    vec_t  vecs[$];

    alu_control_seq dut (
        .Clk         (clk),
        .Rst_n       (rst_n),
        .In_Valid    (in_valid),
        .Flush       (flush),
        .ALUOp       (aluop),
        .IFiveToZero (funct),
        .ALUSignal   (alu_signal),
        .SAControl   (sa_control),
        .ALU_C       (alu_c),
        .HiLoWrite   (hilo_write),
        .Out_Valid   (out_valid),
        .Stall       (stall),
        .Illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic [3:0] sig, input logic sa, input logic jr,
                                input logic hilo, input logic ov, input logic st,
                                input logic ill);
        out_t o;
        o.sig = sig; o.sa = sa; o.jr = jr; o.hilo = hilo;
        o.ov = ov; o.stall = st; o.ill = ill;
        return o;
    endfunction

    function automatic vec_t mkv(input logic v, input logic [2:0] op, input logic [5:0] fn,
                                 input out_t e, input string n);
        vec_t r;
        r.v = v; r.op = op; r.fn = fn; r.exp = e; r.name = n;
        return r;
    endfunction

    // Pop the oldest expectation and compare against the DUT outputs now
    task automatic check_pop();
        out_t  e;
        out_t  a;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = {alu_signal, sa_control, alu_c, hilo_write, out_valid, stall, illegal};
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got sig=%0d sa=%b jr=%b hilo=%b ov=%b stall=%b ill=%b, expected sig=%0d sa=%b jr=%b hilo=%b ov=%b stall=%b ill=%b",
                     n, a.sig, a.sa, a.jr, a.hilo, a.ov, a.stall, a.ill,
                     e.sig, e.sa, e.jr, e.hilo, e.ov, e.stall, e.ill);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check after the edge
    task automatic step(input logic v, input logic f, input logic [2:0] op,
                        input logic [5:0] fn, input out_t e, input string n);
        @(negedge clk);
        in_valid = v;
        flush    = f;
        aluop    = op;
        funct    = fn;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    out_t z;
    out_t mul_busy;
    out_t mul_done;

    initial begin
        z        = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mul_busy = mk(4'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        mul_done = mk(4'd11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Single-cycle decode table
        vecs.push_back(mkv(1'b1, 3'b000, 6'b000011, mk(4'd6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "sra"));
        vecs.push_back(mkv(1'b1, 3'b001, 6'b000011, mk(4'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "op_or"));
        vecs.push_back(mkv(1'b1, 3'b010, 6'b011000, mk(4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "op_add_ignores_funct"));
        vecs.push_back(mkv(1'b1, 3'b011, 6'b000000, mk(4'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "op_sub"));
        vecs.push_back(mkv(1'b1, 3'b100, 6'b000000, mk(4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "op_and"));
        vecs.push_back(mkv(1'b1, 3'b101, 6'b000000, mk(4'd4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "op_xor"));
        vecs.push_back(mkv(1'b1, 3'b110, 6'b000000, mk(4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "op_slt"));
        vecs.push_back(mkv(1'b1, 3'b111, 6'b000000, mk(4'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "op_sltu"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b100000, mk(4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "add"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b100001, mk(4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "addu"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b100010, mk(4'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "sub"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b100011, mk(4'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "subu"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b100100, mk(4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "and"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b100101, mk(4'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "or"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b100110, mk(4'd4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "xor"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b100111, mk(4'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "nor"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b101010, mk(4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "slt"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b101011, mk(4'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "sltu"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b000000, mk(4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "sll"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b000010, mk(4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "srl"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b001000, mk(4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), "jr"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b111111, mk(4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), "illegal_3f"));
        vecs.push_back(mkv(1'b0, 3'b000, 6'b100111, z, "idle_no_valid"));
        vecs.push_back(mkv(1'b1, 3'b000, 6'b000001, mk(4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), "illegal_01"));
        vecs.push_back(mkv(1'b1, 3'b101, 6'b111111, mk(4'd4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "op_xor_ignores_funct"));

        // Reset state
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        aluop    = 3'b000;
        funct    = 6'b000000;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_q.push_back(z);
        name_q.push_back("in_reset");
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset release
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 3'b000, 6'b000000, z, "post_reset_idle");
        end

        // Table-driven single-cycle decode, back-to-back accepts
        foreach (vecs[i]) begin
            step(vecs[i].v, 1'b0, vecs[i].op, vecs[i].fn, vecs[i].exp, vecs[i].name);
        end

        // Multiply: stall for 3 cycles, In_Valid offered during BUSY ignored
        step(1'b1, 1'b0, 3'b000, 6'b011000, mul_busy, "mul_accept");
        step(1'b1, 1'b0, 3'b001, 6'b000000, mul_busy, "mul_busy1_ignore");
        step(1'b1, 1'b0, 3'b000, 6'b100000, mul_busy, "mul_busy2_ignore");
        step(1'b1, 1'b0, 3'b001, 6'b000000, mul_done, "mul_done");
        // New accept in the Out_Valid cycle
        step(1'b1, 1'b0, 3'b001, 6'b000000, mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "accept_after_mul");
        step(1'b1, 1'b0, 3'b000, 6'b011001, mul_busy, "multu_accept");
        step(1'b0, 1'b0, 3'b000, 6'b000000, mul_busy, "multu_busy1");
        step(1'b0, 1'b0, 3'b000, 6'b000000, mul_busy, "multu_busy2");
        step(1'b0, 1'b0, 3'b000, 6'b000000, mul_done, "multu_done");
        step(1'b0, 1'b0, 3'b000, 6'b000000, z, "multu_after_idle");

        // Flush one cycle after a multiply accept: no Out_Valid follows
        step(1'b1, 1'b0, 3'b000, 6'b011000, mul_busy, "flush_mul_accept");
        step(1'b1, 1'b1, 3'b000, 6'b011000, z, "flush_kill");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 3'b000, 6'b000000, z, "flush_no_ov");
        end
        // Flush beats an incoming single-cycle op
        step(1'b1, 1'b1, 3'b000, 6'b001000, z, "flush_over_valid");

        // Reset in the middle of BUSY returns to reset values immediately
        step(1'b1, 1'b0, 3'b000, 6'b011000, mul_busy, "rst_mul_accept");
        step(1'b0, 1'b0, 3'b000, 6'b000000, mul_busy, "rst_mul_busy");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.push_back(z);
        name_q.push_back("async_reset_mid_busy");
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 3'b000, 6'b000000, z, "after_reset_no_ov");
        end

`ifdef ALUCTL_DIV_EN
        // divu: stall for 31 cycles, Out_Valid after the 32nd edge
        step(1'b1, 1'b0, 3'b000, 6'b011011, mk(4'd13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), "divu_accept");
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 3'b001, 6'b000000, mk(4'd13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), "divu_busy");
        end
        step(1'b0, 1'b0, 3'b000, 6'b000000, mk(4'd13, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), "divu_done");
        step(1'b0, 1'b0, 3'b000, 6'b000000, z, "divu_after_idle");
        // div with a reset pulse at cycle 10
        step(1'b1, 1'b0, 3'b000, 6'b011010, mk(4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), "div_accept");
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 3'b000, 6'b000000, mk(4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), "div_busy");
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.push_back(z);
        name_q.push_back("div_reset_cycle10");
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 3'b000, 6'b000000, z, "div_after_reset");
`else
        // Without the divider the div codes are illegal single-cycle ops
        step(1'b1, 1'b0, 3'b000, 6'b011011, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), "divu_illegal");
        step(1'b1, 1'b0, 3'b000, 6'b011010, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), "div_illegal");
        step(1'b0, 1'b0, 3'b000, 6'b000000, z, "div_illegal_idle");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
